// File: rtl/bw_seq_mult_ctrl.sv
// Sequential Baugh-Wooley multiplier: one M-bit partial-product row per cycle,
// correction constant added in a final cycle, start/busy/done handshake.
module bw_seq_mult_ctrl #(
   parameter int M = 7,
   parameter int N = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           tc,
   input  logic [M-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [M+N-1:0] p
);

   localparam int W  = M + N;
   localparam int JW = (N > 1) ? $clog2(N) : 1;

   localparam logic [W-1:0]  ONE_W  = W'(1'b1);
   localparam logic [W-1:0]  ZERO_W = {W{1'b0}};
   localparam logic [W-1:0]  K_TC   = (ONE_W << (W-1)) + (ONE_W << (M-1)) + (ONE_W << (N-1));
   localparam logic [JW-1:0] J_ONE  = JW'(1'b1);
   localparam logic [JW-1:0] J_LAST = JW'(N-1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q;
   logic [M-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic          tc_q;
   logic [JW-1:0] j_q;
   logic [W-1:0]  acc_q;
   logic [W-1:0]  acc_d;
   logic [W-1:0]  fix_d;
   logic [W-1:0]  p_q;
   logic          busy_q;
   logic          done_q;
   logic [M-1:0]  row_s;

   // Row j: a_i & b_j, inverted where exactly one of (MSB column, last row) holds in signed mode.
   function automatic logic [M-1:0] bw_row(input logic [M-1:0] av, input logic bj,
                                           input logic last_row, input logic tcv);
      logic [M-1:0] r;
      for (int i = 0; i < M; i++) begin
         r[i] = (av[i] & bj) ^ (tcv & ((i == M-1) ^ last_row));
      end
      return r;
   endfunction

   always_comb begin
      row_s = bw_row(a_q, b_q[j_q], (j_q == J_LAST), tc_q);
      acc_d = acc_q + ({{N{1'b0}}, row_s} << j_q);
      fix_d = acc_q + (tc_q ? K_TC : ZERO_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= {M{1'b0}};
         b_q     <= {N{1'b0}};
         tc_q    <= 1'b0;
         j_q     <= {JW{1'b0}};
         acc_q   <= ZERO_W;
         p_q     <= ZERO_W;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  tc_q    <= tc;
                  acc_q   <= ZERO_W;
                  j_q     <= {JW{1'b0}};
                  busy_q  <= 1'b1;
                  state_q <= S_ITER;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            S_ITER: begin
               acc_q <= acc_d;
               j_q   <= j_q + J_ONE;
               if (j_q == J_LAST) begin
                  state_q <= S_FIX;
               end else begin
                  state_q <= S_ITER;
               end
            end
            S_FIX: begin
               acc_q   <= fix_d;
               p_q     <= fix_d;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: doc/bw_seq_mult_ctrl.md
Name: bw_seq_mult_ctrl

Overview:
- Sequential Baugh-Wooley multiplier controller for the multiplier datapath.
- Reuses a single row of M two-AND/T-inversion full-adder cells and processes one multiplier bit per cycle, accumulating shifted partial-product rows.
- Final cycle adds the Baugh-Wooley correction constant; result is presented with a start/busy/done handshake.
- Provides a cheaper alternative to the fully parallel 7x5 array; supports signed (two's complement) and unsigned modes.

Parameters:
- M, 7, multiplicand width (a).
- N, 5, multiplier width (b).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- tc  input  1  1 = signed two's complement operands, 0 = unsigned; latched with start.
- a  input  M  multiplicand; latched with start.
- b  input  N  multiplier; latched with start.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; p is valid from this cycle onward.
- p  output  M+N  product register; holds its value until the next done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, p=0, accumulator=0, row counter j=0, latched operands=0.
- Reset mid-operation: the operation is aborted immediately. No done pulse is produced, and p returns to 0.
- FSM states and transitions:
  - IDLE --start--> ITER. On this edge, latch a, b and tc; clear the accumulator; set j=0.
  - ITER: exactly N cycles, j=0..N-1. Each edge adds row_j<<j to the accumulator (M+N bits, modulo 2^(M+N)). j increments; on j=N-1 go to FIX.
  - FIX: one cycle. Add the constant K to the accumulator. Load p with the result. Go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Row generation for row j, bit i: pp = a_i & b_j, then XOR with T.
  - T=1 when tc=1 and exactly one of {i=M-1, j=N-1} holds (Baugh-Wooley inversion).
  - Otherwise T=0. When tc=0, T=0 always.
- Correction constant:
  - tc=1: K = 2^(M+N-1) + 2^(M-1) + 2^(N-1), modulo 2^(M+N). For M=7, N=5 this is 0x850.
  - tc=0: K = 0.
- Latency: start sampled at edge k; p updated and done high after edge k+N+1; back in IDLE after edge k+N+2. For N=5, done appears 6 edges after start.
- busy: 1 in ITER, FIX and DONE; 0 in IDLE.
- start handling:
  - start while busy (including the DONE cycle) is ignored and not queued.
  - Back-to-back operation requires start high in the first IDLE cycle.
  - Operand or tc changes after acceptance have no effect on the current operation.
- Width rules: the accumulator and p are exactly M+N bits, and overflow carries are discarded. Signed results are the two's complement product; unsigned results are the exact product. No product can overflow M+N bits.

Test Plan:
- Reset, idle, then tc=1, a=7'h40 (-64), b=5'h10 (-16), start pulse. Required: busy rises next cycle; done pulses once, 6 edges after start; p=12'h400 (1024).
- tc=1 sign mixes:
  - a=63, b=15 -> p=12'h3B1.
  - a=-64, b=15 -> p=12'hC40 (-960).
  - a=-1, b=1 -> p=12'hFFF.
  - a=0, b=-16 -> p=12'h000.
- tc=0 unsigned, a=7'h7F, b=5'h1F. Required: p=12'hF61 (3937), with no correction applied.
- Start accepted with a=5, b=3. Then change a/b and toggle tc while busy, and assert start every cycle until done. Required: p=12'h00F; exactly one done pulse; the second operation starts only from IDLE, with done 6 edges later.
- Start accepted, then rst_n low at ITER j=2 for one cycle asynchronously. Required: busy=0, done=0 and p=0 immediately; no later done pulse. A new start after rst_n releases completes normally.
- Randomised 500 operand pairs per tc mode, compared against a signed/unsigned reference model. Required: all match, and p holds steady between done pulses.
